// File: rtl/suspi_pkt_tx.sv
// suspi_pkt_tx -- SUSPI link response packet transmitter.
//
// On an accepted start pulse it sends one packet on DATA:
//   MARKER, flag, length[15:8], length[7:0], payload[0..length-1], crc[15:8], crc[7:0]
// Each byte goes out as an 11-bit frame: start 0, 8 data bits LSB first,
// odd parity (~^byte), stop 1. Bit timing comes from a CLK_DIV clock-enable
// divider on bb_clk_in. CRC is CRC-16/CCITT (0x1021, init FFFF, MSB first)
// over header and payload bytes.
//
// Ports:
//   bb_clk_in, rst_l         system clock / async active-low reset
//   start, flag, length      packet request (flag/length sampled on accept)
//   len_err                  1-cycle pulse: start rejected, length > MAX_LEN
//   rd_req, rd_addr          payload fetch request, held until rd_rdy
//   rd_rdy, rd_data          fetch acknowledge with data in the same cycle
//   DATA                     serial line, idle high, registered
//   busy, done               packet in flight / 1-cycle end-of-packet pulse
module suspi_pkt_tx #(
  parameter int         CLK_DIV = 12,
  parameter logic [7:0] MARKER  = 8'hB6,
  parameter int         MAX_LEN = 2047,
  parameter int         AW      = 11
) (
  input  logic          bb_clk_in,
  input  logic          rst_l,
  input  logic          start,
  input  logic [7:0]    flag,
  input  logic [15:0]   length,
  output logic          len_err,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_rdy,
  input  logic [7:0]    rd_data,
  output logic          DATA,
  output logic          busy,
  output logic          done
);
  localparam int DW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, HDR, PAY, CRC} state_t;

  typedef struct packed {
    logic [7:0]  flag;
    logic [15:0] len;
  } pkt_req_t;

  state_t        state;
  pkt_req_t      req_q;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_idx;   // bit of the current frame now on DATA
  logic [10:0]   frame;     // bit 0 = start bit
  logic [15:0]   fidx;      // packet byte index of the frame on the line
  logic [15:0]   crc;
  logic [7:0]    hold;      // one-byte payload prefetch register
  logic          hold_vld;
  logic          stall;     // underrun: stretched stop, divider parked

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction

  function automatic logic [10:0] mk_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  logic [15:0] nxt_idx;
  logic [7:0]  nxt_byte;
  logic        nxt_pay, last_frame, bit_end, frame_end;

  // Selects the byte for the frame after the current one.
  always_comb begin
    nxt_idx    = fidx + 16'd1;
    nxt_pay    = (nxt_idx >= 16'd4) && (nxt_idx < req_q.len + 16'd4);
    last_frame = (fidx == req_q.len + 16'd5);
    bit_end    = (div_cnt == DW'(CLK_DIV - 1));
    frame_end  = stall || (bit_end && bit_idx == 4'd10);
    nxt_byte   = crc[7:0];
    if (nxt_idx == 16'd1)                    nxt_byte = req_q.flag;
    else if (nxt_idx == 16'd2)               nxt_byte = req_q.len[15:8];
    else if (nxt_idx == 16'd3)               nxt_byte = req_q.len[7:0];
    else if (nxt_pay)                        nxt_byte = hold;
    else if (nxt_idx == req_q.len + 16'd4)   nxt_byte = crc[15:8];
  end

  always_ff @(posedge bb_clk_in or negedge rst_l) begin
    if (!rst_l) begin
      state    <= IDLE;
      req_q    <= '0;
      DATA     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      len_err  <= 1'b0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      div_cnt  <= '0;
      bit_idx  <= '0;
      frame    <= '1;
      fidx     <= '0;
      crc      <= '1;
      hold     <= '0;
      hold_vld <= 1'b0;
      stall    <= 1'b0;
    end else begin
      done    <= 1'b0;
      len_err <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (length > 16'(MAX_LEN)) begin
            len_err <= 1'b1;
          end else begin
            req_q.flag <= flag;
            req_q.len  <= length;
            crc        <= crc_upd(16'hFFFF, MARKER);
            frame      <= mk_frame(MARKER);
            DATA       <= 1'b0;           // marker start bit goes out now
            fidx       <= '0;
            div_cnt    <= '0;
            bit_idx    <= '0;
            rd_addr    <= '0;
            hold_vld   <= 1'b0;
            stall      <= 1'b0;
            busy       <= 1'b1;
            state      <= HDR;
          end
        end
      end else if (frame_end) begin
        if (last_frame) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          DATA  <= 1'b1;
        end else if (nxt_pay && !hold_vld) begin
          // Payload byte not here yet: keep the line at stop level and
          // re-evaluate every cycle with the divider parked.
          stall   <= 1'b1;
          div_cnt <= '0;
        end else begin
          frame   <= mk_frame(nxt_byte);
          DATA    <= 1'b0;
          fidx    <= nxt_idx;
          div_cnt <= '0;
          bit_idx <= '0;
          stall   <= 1'b0;
          if (nxt_idx < req_q.len + 16'd4) crc <= crc_upd(crc, nxt_byte);
          if (nxt_pay) hold_vld <= 1'b0;
          // Frame k (k >= 3) prefetches payload byte k-3 for the next frame.
          if (nxt_idx >= 16'd3 && nxt_idx < req_q.len + 16'd3) rd_req <= 1'b1;
          state   <= (nxt_idx < 16'd4) ? HDR : (nxt_pay ? PAY : CRC);
        end
      end else if (bit_end) begin
        div_cnt <= '0;
        bit_idx <= bit_idx + 4'd1;
        DATA    <= frame[bit_idx + 4'd1];
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (rd_req && rd_rdy) begin
        hold     <= rd_data;
        hold_vld <= 1'b1;
        rd_req   <= 1'b0;
        if (rd_addr != AW'(req_q.len - 16'd1)) rd_addr <= rd_addr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_suspi_pkt_tx.sv
// Testbench for suspi_pkt_tx: directed packet scenarios with randomized
// payload RAM contents and spurious rd_rdy pulses; the DATA line is recorded
// per cycle and decoded against a byte-list + bit-serial CRC model.
module tb_suspi_pkt_tx;
  localparam int         CDIV = 2;
  localparam int         MAXL = 2047;
  localparam logic [7:0] MK   = 8'hB6;

  typedef logic [7:0] bq_t[$];

  logic        bb_clk_in, rst_l, start;
  logic [7:0]  flag;
  logic [15:0] length;
  logic        len_err, rd_req;
  logic [10:0] rd_addr;
  logic        rd_rdy;
  logic [7:0]  rd_data;
  logic        DATA, busy, done;

  int vectors = 0, miscompares = 0;
  logic [7:0] ram [0:2047];
  int rd_cnt [0:2047];
  int max_addr, req_seen, stall_addr, stall_cyc;

  suspi_pkt_tx #(.CLK_DIV(CDIV), .MARKER(MK), .MAX_LEN(MAXL), .AW(11)) dut (
    .bb_clk_in(bb_clk_in), .rst_l(rst_l), .start(start), .flag(flag), .length(length),
    .len_err(len_err), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .rd_data(rd_data), .DATA(DATA), .busy(busy), .done(done)
  );

  initial begin
    bb_clk_in = 1'b0;
    forever #5 bb_clk_in = ~bb_clk_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial CRC-16/CCITT over the whole message.
  function automatic logic [15:0] crc_ref(input bq_t m);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (m[i])
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ m[i][b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    return c;
  endfunction

  function automatic bq_t build(input logic [7:0] f, input int len);
    bq_t q;
    logic [15:0] l16, c;
    l16 = 16'(len);
    q.push_back(MK);
    q.push_back(f);
    q.push_back(l16[15:8]);
    q.push_back(l16[7:0]);
    for (int i = 0; i < len; i++) q.push_back(ram[i]);
    c = crc_ref(q);
    q.push_back(c[15:8]);
    q.push_back(c[7:0]);
    return q;
  endfunction

  // Payload RAM responder: acks requests (optionally late on one address)
  // and throws random rd_rdy pulses while no request is pending.
  initial begin
    int req_cyc;
    req_cyc = 0;
    rd_rdy  = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(negedge bb_clk_in);
      rd_rdy = 1'b0;
      if (rd_req === 1'b1) begin
        req_seen++;
        req_cyc++;
        if (!(int'(rd_addr) == stall_addr && req_cyc < stall_cyc)) begin
          rd_rdy  = 1'b1;
          rd_data = ram[rd_addr];
          rd_cnt[rd_addr]++;
          if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
          req_cyc = 0;
        end
      end else begin
        req_cyc = 0;
        if ($urandom_range(7) == 0) begin
          rd_rdy  = 1'b1;
          rd_data = 8'($urandom);
        end
      end
    end
  end

  task automatic rand_ram();
    for (int i = 0; i < 2048; i++) ram[i] = 8'($urandom);
  endtask

  // Send one packet, record DATA each cycle, decode and check it.
  // abort_frame >= 0: pull reset a few cycles into that frame instead.
  // poke: issue extra starts (one over-length) while busy.
  task automatic run_pkt(input logic [7:0] f, input int len, input int abort_frame, input bit poke);
    bq_t  exp;
    logic lq[$];
    int   cyc, done_idx, lerr, pos, gap, tot_gap, bad_gap, wbad, limit, bad;
    logic [10:0] fb;
    logic seen_done, busy_at_done;
    exp = build(f, len);
    for (int i = 0; i < 2048; i++) rd_cnt[i] = 0;
    max_addr = -1;
    req_seen = 0;
    @(negedge bb_clk_in);
    start = 1'b1; flag = f; length = 16'(len);
    @(negedge bb_clk_in);
    start = 1'b0;
    chk("busy_rise", busy, 1);
    limit = (6 + len) * 11 * CDIV + 400;
    cyc = 0; seen_done = 0; lerr = 0; done_idx = -1; busy_at_done = 1'b1;
    while (!seen_done && cyc < limit) begin
      lq.push_back(DATA);
      if (len_err) lerr++;
      if (done) begin
        seen_done = 1'b1;
        done_idx = cyc;
        busy_at_done = busy;
      end else begin
        start = poke && (cyc == 40 || cyc == 70);
        if (poke && cyc == 40) begin flag = ~f; length = 16'd3000; end
        if (poke && cyc == 70) begin flag = ~f; length = 16'd5; end
        if (abort_frame >= 0 && cyc == abort_frame * 11 * CDIV + 3) begin
          rst_l = 1'b0;
          #1;
          chk("rst_data", DATA, 1);
          chk("rst_busy", busy, 0);
          chk("rst_rd_req", rd_req, 0);
          chk("rst_rd_addr", rd_addr, 0);
          chk("rst_done", done, 0);
          repeat (3) @(negedge bb_clk_in);
          rst_l = 1'b1;
          bad = 0;
          repeat (30) begin
            @(negedge bb_clk_in);
            if (done !== 1'b0 || busy !== 1'b0 || DATA !== 1'b1) bad++;
          end
          chk("abandoned_quiet", bad, 0);
          return;
        end
        @(negedge bb_clk_in);
        cyc++;
      end
    end
    start = 1'b0;
    chk("done_seen", seen_done, 1);
    chk("busy_at_done", busy_at_done, 0);
    @(negedge bb_clk_in);
    chk("done_one_cycle", done, 0);

    pos = 0; tot_gap = 0; bad_gap = 0; wbad = 0;
    foreach (exp[k]) begin
      gap = 0;
      while (pos < lq.size() && lq[pos] == 1'b1) begin gap++; pos++; end
      tot_gap += gap;
      if (gap != 0 && k != 4 + stall_addr) bad_gap++;
      for (int b = 0; b < 11; b++) begin
        if (pos + CDIV > lq.size()) fb[b] = 1'bx;
        else begin
          fb[b] = lq[pos];
          for (int j = 1; j < CDIV; j++) if (lq[pos + j] !== lq[pos]) wbad++;
        end
        pos += CDIV;
      end
      chk($sformatf("frame%0d_byte", k), fb[8:1], exp[k]);
      chk($sformatf("frame%0d_parity", k), fb[9], ($countones(exp[k]) % 2 == 0));
      chk($sformatf("frame%0d_stop", k), fb[10], 1);
    end
    chk("bit_width", wbad, 0);
    chk("gap_placement", bad_gap, 0);
    chk("pkt_cycles", done_idx, (6 + len) * 11 * CDIV + tot_gap);
    if (stall_addr >= 0 && stall_addr < len) chk("underrun_gap", tot_gap > 0, 1);
    else chk("no_gap", tot_gap, 0);
    chk("len_err_quiet", lerr, 0);
    bad = 0;
    for (int i = 0; i < len; i++) if (rd_cnt[i] != 1) bad++;
    chk("reads_once", bad, 0);
    chk("last_addr", max_addr, len - 1);
    if (len == 0) chk("no_rd_req", req_seen, 0);
  endtask

  task automatic reject(input logic [15:0] l);
    int bad;
    @(negedge bb_clk_in);
    start = 1'b1; length = l; flag = 8'hFF;
    @(negedge bb_clk_in);
    start = 1'b0;
    chk("len_err_pulse", len_err, 1);
    chk("reject_busy", busy, 0);
    chk("reject_data", DATA, 1);
    @(negedge bb_clk_in);
    chk("len_err_clear", len_err, 0);
    bad = 0;
    repeat (20) begin
      @(negedge bb_clk_in);
      if (DATA !== 1'b1 || busy !== 1'b0 || rd_req !== 1'b0) bad++;
    end
    chk("reject_idle", bad, 0);
  endtask

  initial begin
    bq_t m;
    stall_addr = -1; stall_cyc = 0;
    rst_l = 1'b0; start = 1'b0; flag = 8'h00; length = 16'h0000;
    for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
    repeat (3) @(negedge bb_clk_in);
    chk("reset_data", DATA, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_len_err", len_err, 0);
    chk("reset_rd_req", rd_req, 0);
    chk("reset_rd_addr", rd_addr, 0);
    rst_l = 1'b1;
    repeat (2) @(negedge bb_clk_in);
    chk("idle_data", DATA, 1);

    for (int i = 0; i < 9; i++) m.push_back(8'h31 + 8'(i));
    chk("crc_selftest", crc_ref(m), 16'h29B1);

    // status packet, no payload
    run_pkt(8'h02, 0, -1, 0);
    // 16-byte payload, RAM[i] = i
    for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    run_pkt(8'h04, 16, -1, 0);
    // late acknowledge on byte 5
    rand_ram();
    stall_addr = 5; stall_cyc = 40;
    run_pkt(8'($urandom), 16, -1, 0);
    stall_addr = -1;
    // rejections
    reject(16'd2048);
    reject(16'($urandom_range(2049, 65535)));
    // starts while busy are ignored
    rand_ram();
    run_pkt(8'h5A, 3, -1, 1);
    // reset during payload frame 3, then a clean packet
    run_pkt(8'h11, 8, 6, 0);
    run_pkt(8'h11, 8, -1, 0);
    // random packets
    repeat (4) begin
      rand_ram();
      run_pkt(8'($urandom), $urandom_range(1, 24), -1, 0);
    end
    // maximum length
    rand_ram();
    run_pkt(8'hA5, MAXL, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/suspi_pkt_tx.md
# suspi_pkt_tx

Serial packet transmitter for the SUSPI link: on a start pulse it builds a response packet (marker, flag, 16-bit length, payload bytes fetched from the TX buffer RAM, CRC-16) and serialises every byte as an 11-bit frame on `DATA`. It is the transmit-side counterpart of the SUSPI command receiver and drives the `DATA1`/`DATA2` line in the top level. Bit timing is derived from the 12 MHz system clock with a clock-enable divider; no second clock is used.

## Interface
- `CLK_DIV`, 12: system clocks per serial bit (12 MHz / 12 = 1 Mbit/s); legal ≥ 2.
- `MARKER`, 8'hB6: first byte of every packet.
- `MAX_LEN`, 2047: largest payload length accepted.
- `AW`, 11: payload RAM address width.

- `bb_clk_in` in 1: system clock, 12 MHz, all logic on rising edge.
- `rst_l` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request to send a packet; ignored while `busy`.
- `flag` in 8: packet flag byte, sampled on accepted `start`.
- `length` in 16: payload byte count, sampled on accepted `start`.
- `len_err` out 1: one-cycle pulse when `start` is rejected because `length > MAX_LEN`.
- `rd_req` out 1: payload read request, held until `rd_rdy`.
- `rd_addr` out AW: payload address, stable while `rd_req` high.
- `rd_rdy` in 1: read acknowledge; `rd_data` valid in the same cycle.
- `rd_data` in 8: payload byte.
- `DATA` out 1: serial line, idle high.
- `busy` out 1: high from accepted `start` through last stop bit.
- `done` out 1: one-cycle pulse after the last stop bit of the packet.

## Operation
- Frame: start bit 0, data bits LSB first, parity bit, stop bit 1; 11 bits. Parity is odd: parity bit = ~^byte.
- Byte order: `MARKER`, `flag`, `length[15:8]`, `length[7:0]`, payload[0..length-1] from `rd_addr` 0..length-1, `crc[15:8]`, `crc[7:0]`.
- CRC: CRC-16/CCITT, polynomial 0x1021, init 16'hFFFF, MSB-first, no reflection, no final XOR; byte-wise update over marker, flag, both length bytes and all payload bytes. CRC bytes themselves are not included.
- States: IDLE → HDR (4 header frames) → PAY (length frames; skipped if length = 0) → CRC (2 frames) → IDLE.
- Accepted `start` (IDLE, `length ≤ MAX_LEN`): latch flag/length, load CRC = FFFF, reset address to 0, assert `busy` next cycle.
- `start` with `length > MAX_LEN` in IDLE: `len_err` pulse, no frame sent, `busy` stays low.
- `start` while `busy`: ignored, no `len_err`.
- Prefetch: `rd_req` for payload byte n is raised at the start of the frame preceding it (the last header frame for byte 0); one-byte holding register.
- Underrun: if the holding register is empty at a frame boundary, `DATA` stays high (stretched stop) and the bit divider holds; the next frame begins on the first bit boundary after `rd_rdy`.
- `rd_addr` increments by 1 per accepted byte, no wrap beyond length-1; `rd_req` never asserted for length = 0.

## Timing
- Reset values: `DATA`=1, `busy`=0, `done`=0, `len_err`=0, `rd_req`=0, `rd_addr`=0; state IDLE, divider 0.
- `DATA` is registered. Start bit of the marker frame appears 1 cycle after the accepted `start`.
- Each bit lasts exactly `CLK_DIV` cycles; frames follow back-to-back with no gap unless underrun.
- Packet length without underrun: (6 + length) × 11 × `CLK_DIV` cycles from first start-bit edge to end of last stop bit.
- `done` pulses in the cycle after the last stop bit completes; `busy` falls in the same cycle.
- `rst_l` low mid-packet: all outputs to reset values immediately (async), packet abandoned, no `done`.
- `rd_rdy` without `rd_req` ignored.

## Test plan
- Status packet: flag=8'h02, length=0 → frames B6,02,00,00,crc_hi,crc_lo; CRC matches bench model (model self-check: "123456789" → 16'h29B1); `done` 792 cycles after start bit; no `rd_req`.
- Payload: flag=8'h04, length=16, RAM[i]=i, `rd_rdy` same cycle → 22 frames, payload 00..0F, parity bits checked per byte (0x00 → parity 1, 0x01 → parity 0), addresses 0..15 each read once.
- Underrun: `rd_rdy` delayed 40 cycles on byte 5 → `DATA` held high between frames 9 and 10, no glitch, all bits still `CLK_DIV` wide, CRC correct.
- Rejection: `start` with length=2048 → `len_err` pulse, `DATA` idle; `start` while busy → ignored, packet unaltered.
- Reset: `rst_l` low during payload frame 3 → `DATA`=1, `busy`=0 same cycle; new `start` after release sends a full correct packet.
- Max length: length=2047 → last `rd_addr`=2046, correct CRC, `done` after 2053 frames.
